// File: rtl/dma_oam_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_oam_if
// Brief    : Trigger and memory-bus handshake signals of the OAM DMA engine.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_oam_if;
    logic        trig;
    logic [7:0]  trigpage;
    logic        halt;
    logic [15:0] dmaaddr;
    logic [7:0]  dmawdata;
    logic        dmawr;
    logic        dmareq;
    logic        dmaack;
    logic [7:0]  memrdata;
    logic        dmadone;
    logic        busy;

    // Engine side: receives the trigger and bus responses, drives the bus.
    modport master (
        input  trig, trigpage, dmaack, memrdata,
        output halt, dmaaddr, dmawdata, dmawr, dmareq, dmadone, busy
    );

    // CPU/memory side: issues the trigger and answers bus requests.
    modport slave (
        output trig, trigpage, dmaack, memrdata,
        input  halt, dmaaddr, dmawdata, dmawr, dmareq, dmadone, busy
    );
endinterface
`default_nettype wire

// File: rtl/dma_oam.sv
`default_nettype none
// ============================================================================
// Module   : dma_oam
// Brief    : Sprite DMA engine. Copies one 256-byte page to a fixed write
//            address as 512 alternating read/write bus accesses while holding
//            the CPU off the bus.
// Revision : 1.0 - initial release
// ============================================================================
module dma_oam #(
    parameter logic [15:0] DESTADDR = 16'h2004,
    parameter int          SETTLE   = 1
) (
    input  logic       clk,
    input  logic       rst,
    dma_oam_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_RD     = 3'd2,
        S_RGAP   = 3'd3,
        S_WR     = 3'd4,
        S_WGAP   = 3'd5
    } state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] C_SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t          r_state, w_state;
    logic [7:0]      r_page,  w_page;
    logic [7:0]      r_idx,   w_idx;
    logic [CW-1:0]   r_cnt,   w_cnt;
    logic [7:0]      r_dbuf,  w_dbuf;
    logic            r_halt,  w_halt;
    logic            r_busy,  w_busy;
    logic            r_req,   w_req;
    logic            r_wr,    w_wr;
    logic [15:0]     r_addr,  w_addr;
    logic [7:0]      r_wdata, w_wdata;
    logic            r_done,  w_done;

    // Every output is a flop; the next-state logic below precomputes the
    // value each output takes on entry to the following state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_cnt   <= '0;
            r_dbuf  <= 8'h00;
            r_halt  <= 1'b0;
            r_busy  <= 1'b0;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_page  <= w_page;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_dbuf  <= w_dbuf;
            r_halt  <= w_halt;
            r_busy  <= w_busy;
            r_req   <= w_req;
            r_wr    <= w_wr;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_done  <= w_done;
        end
    end

    // Next-state and next-output logic; acks are only looked at in RD/WR,
    // and trig only in IDLE, so stray strobes elsewhere fall through.
    always_comb begin
        w_state = r_state;
        w_page  = r_page;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_dbuf  = r_dbuf;
        w_halt  = r_halt;
        w_busy  = r_busy;
        w_req   = r_req;
        w_wr    = r_wr;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.trig) begin
                    w_page = bus.trigpage;
                    w_idx  = 8'h00;
                    w_cnt  = '0;
                    w_halt = 1'b1;
                    w_busy = 1'b1;
                    if (SETTLE == 0) begin
                        w_state = S_RD;
                        w_req   = 1'b1;
                        w_wr    = 1'b0;
                        w_addr  = {bus.trigpage, 8'h00};
                    end else begin
                        w_state = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (r_cnt == C_SETTLE_LAST) begin
                    w_state = S_RD;
                    w_req   = 1'b1;
                    w_wr    = 1'b0;
                    w_addr  = {r_page, r_idx};
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_RD: begin
                if (bus.dmaack) begin
                    w_dbuf  = bus.memrdata;
                    w_req   = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_RGAP;
                end
            end
            S_RGAP: begin
                // The slave reacts to a rising request, so one low cycle
                // separates the read from the write.
                w_state = S_WR;
                w_req   = 1'b1;
                w_wr    = 1'b1;
                w_addr  = DESTADDR;
                w_wdata = r_dbuf;
            end
            S_WR: begin
                if (bus.dmaack) begin
                    w_req   = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_WGAP;
                end
            end
            S_WGAP: begin
                if (r_idx == 8'hFF) begin
                    w_state = S_IDLE;
                    w_halt  = 1'b0;
                    w_busy  = 1'b0;
                end else begin
                    // Index wraps within the page; never carries into it.
                    w_idx   = r_idx + 8'd1;
                    w_state = S_RD;
                    w_req   = 1'b1;
                    w_wr    = 1'b0;
                    w_addr  = {r_page, r_idx + 8'd1};
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.halt     = r_halt;
    assign bus.busy     = r_busy;
    assign bus.dmareq   = r_req;
    assign bus.dmawr    = r_wr;
    assign bus.dmaaddr  = r_addr;
    assign bus.dmawdata = r_wdata;
    assign bus.dmadone  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dma_oam.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_oam
// Brief    : Self-checking bench for dma_oam. A behavioural memory slave
//            answers requests with random latency and logs every acknowledged
//            access; each transfer is compared with the access list expected
//            from the page contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_oam;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dma_oam_if bus ();

    dma_oam #(
        .DESTADDR (16'h2004),
        .SETTLE   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [0:65535];
    acc_t       obs[$];
    acc_t       exp_q[$];
    acc_t       slave_acc;

    int total = 0;
    int bad = 0;
    int proto_err = 0;
    int hb_err = 0;
    int done_cnt = 0;
    int max_delay = 0;
    int cur_delay = 0;
    int wait_cnt = 0;
    bit pend = 1'b0;
    bit stall = 1'b0;

    // Memory slave: acks a held request after a random delay, returns read
    // data from the memory model, and flags handshake rule violations.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            bus.dmaack   = 1'b0;
            bus.memrdata = 8'h00;
            pend         = 1'b0;
            wait_cnt     = 0;
        end else if (bus.dmaack === 1'b1) begin
            bus.dmaack = 1'b0;
            pend       = 1'b0;
            wait_cnt   = 0;
            if (bus.dmareq !== 1'b0) proto_err++;
        end else if (bus.dmareq === 1'b1) begin
            pend = 1'b1;
            if (!stall && wait_cnt >= cur_delay) begin
                bus.dmaack     = 1'b1;
                bus.memrdata   = bus.dmawr ? 8'($urandom) : mem[bus.dmaaddr];
                slave_acc.wr   = bus.dmawr;
                slave_acc.addr = bus.dmaaddr;
                slave_acc.data = bus.dmawr ? bus.dmawdata : 8'h00;
                obs.push_back(slave_acc);
                cur_delay      = int'($urandom_range(max_delay, 0));
            end else begin
                wait_cnt++;
            end
        end else begin
            if (pend) proto_err++;
            pend = 1'b0;
        end
    end

    // Counts done pulses and flags any cycle where halt and busy disagree.
    always @(negedge clk) begin
        if (bus.dmadone === 1'b1) done_cnt++;
        if (bus.halt !== bus.busy) hb_err++;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Reference: 256 read/write pairs over the page, data straight from memory.
    task automatic build_exp(input logic [7:0] p);
        acc_t a;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            a.wr   = 1'b0;
            a.addr = {p, 8'(i)};
            a.data = 8'h00;
            exp_q.push_back(a);
            a.wr   = 1'b1;
            a.data = mem[{p, 8'(i)}];
            a.addr = 16'h2004;
            exp_q.push_back(a);
        end
    endtask

    task automatic fill_random(input logic [7:0] p);
        for (int i = 0; i < 256; i++) mem[{p, 8'(i)}] = 8'($urandom);
    endtask

    task automatic clear_log();
        obs.delete();
        done_cnt  = 0;
        proto_err = 0;
        hb_err    = 0;
    endtask

    task automatic pulse_trig(input logic [7:0] p);
        @(negedge clk);
        bus.trig     = 1'b1;
        bus.trigpage = p;
        @(negedge clk);
        bus.trig     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy === 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_timeout", tag), 32'(n < 20000), 32'd1);
    endtask

    task automatic cmp_seq(input string tag);
        chk($sformatf("%s_len", tag), 32'(obs.size()), 32'd512);
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk($sformatf("%s_acc%0d", tag, i), 32'(obs[i]), 32'(exp_q[i]));
        chk($sformatf("%s_done", tag), 32'(done_cnt), 32'd512);
        chk($sformatf("%s_proto", tag), 32'(proto_err), 32'd0);
        chk($sformatf("%s_halt", tag), 32'(hb_err), 32'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int zeros;
        int viol;
        logic [15:0] snap;

        bus.trig     = 1'b0;
        bus.trigpage = 8'h00;
        rst          = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_halt",  32'(bus.halt),     32'd0);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        chk("rst_req",   32'(bus.dmareq),   32'd0);
        chk("rst_wr",    32'(bus.dmawr),    32'd0);
        chk("rst_done",  32'(bus.dmadone),  32'd0);
        chk("rst_addr",  32'(bus.dmaaddr),  32'd0);
        chk("rst_wdata", 32'(bus.dmawdata), 32'd0);
        rst = 1'b0;

        // Basic copy of page 02, immediate acks
        for (int i = 0; i < 256; i++) mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'h5A;
        max_delay = 0;
        build_exp(8'h02);
        clear_log();
        pulse_trig(8'h02);
        chk("settle_halt", 32'(bus.halt),   32'd1);
        chk("settle_busy", 32'(bus.busy),   32'd1);
        chk("settle_req",  32'(bus.dmareq), 32'd0);
        @(negedge clk);
        chk("first_req",  32'(bus.dmareq),  32'd1);
        chk("first_wr",   32'(bus.dmawr),   32'd0);
        chk("first_addr", 32'(bus.dmaaddr), 32'h0200);
        wait_idle("basic");
        cmp_seq("basic");
        chk("basic_end_busy", 32'(bus.busy), 32'd0);
        chk("basic_end_halt", 32'(bus.halt), 32'd0);

        // Page FF with random ack latency: source address must not carry
        fill_random(8'hFF);
        max_delay = 5;
        build_exp(8'hFF);
        clear_log();
        pulse_trig(8'hFF);
        wait_idle("wrap");
        cmp_seq("wrap");
        zeros = 0;
        foreach (obs[i]) if (obs[i].addr == 16'h0000) zeros++;
        chk("wrap_no_zero", 32'(zeros), 32'd0);

        // Retrigger mid-transfer and at the final cycle must be ignored
        fill_random(8'h03);
        fill_random(8'h07);
        max_delay = 2;
        build_exp(8'h03);
        clear_log();
        pulse_trig(8'h03);
        n = 0;
        while (obs.size() < 40 && n < 20000) begin @(negedge clk); n++; end
        chk("retrig_wait40", 32'(n < 20000), 32'd1);
        pulse_trig(8'h07);
        n = 0;
        while (!(obs.size() == 512 && bus.dmadone === 1'b1) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("retrig_wait_end", 32'(n < 20000), 32'd1);
        bus.trig     = 1'b1;
        bus.trigpage = 8'h07;
        @(negedge clk);
        bus.trig     = 1'b0;
        chk("retrig_end_busy", 32'(bus.busy), 32'd0);
        repeat (20) @(negedge clk);
        chk("retrig_still_idle", 32'(bus.busy), 32'd0);
        chk("retrig_halt_low",   32'(bus.halt), 32'd0);
        cmp_seq("retrig");

        // Reset after the 100th write, then restart on page 04
        fill_random(8'h05);
        max_delay = 3;
        clear_log();
        pulse_trig(8'h05);
        n = 0;
        while (obs.size() < 200 && n < 20000) begin @(negedge clk); n++; end
        chk("rstmid_wait", 32'(n < 20000), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_halt", 32'(bus.halt),   32'd0);
        chk("rstmid_req",  32'(bus.dmareq), 32'd0);
        chk("rstmid_busy", 32'(bus.busy),   32'd0);
        rst = 1'b0;
        fill_random(8'h04);
        build_exp(8'h04);
        repeat (2) @(negedge clk);
        clear_log();
        pulse_trig(8'h04);
        wait_idle("restart");
        cmp_seq("restart");

        // Withheld ack in RD: bus must freeze, then finish normally
        fill_random(8'h06);
        max_delay = 1;
        build_exp(8'h06);
        clear_log();
        pulse_trig(8'h06);
        n = 0;
        while (obs.size() < 10 && n < 20000) begin @(negedge clk); n++; end
        chk("stall_wait", 32'(n < 20000), 32'd1);
        stall = 1'b1;
        repeat (4) @(negedge clk);
        snap = bus.dmaaddr;
        chk("stall_addr", 32'(snap),       32'h0605);
        chk("stall_req",  32'(bus.dmareq), 32'd1);
        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.dmareq !== 1'b1 || bus.halt !== 1'b1 || bus.dmaaddr !== snap) viol++;
        end
        chk("stall_stable", 32'(viol), 32'd0);
        stall = 1'b0;
        wait_idle("stall");
        cmp_seq("stall");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_oam.md
DMA_OAM -- requirements
Module: dma_oam

Interface
REQ-001 Parameter: DESTADDR, default 16'h2004, write target for every copied byte.
REQ-002 Parameter: SETTLE, default 1, idle cycles between halt assertion and the first request.
REQ-003 Timing SHALL be one clock and reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 trig  input  1  one-cycle strobe: CPU write to $4014 accepted.
REQ-007 trigpage  input  8  source page (high address byte), valid with trig.
REQ-008 halt  output  1  high while the engine owns the memory bus.
REQ-009 dmaaddr  output  16  bus address.
REQ-010 dmawdata  output  8  write data.
REQ-011 dmawr  output  1  1 = write, 0 = read.
REQ-012 dmareq  output  1  request level, held until acknowledged.
REQ-013 dmaack  input  1  one-cycle acknowledge from the bus.
REQ-014 memrdata  input  8  read data, valid in the cycle dmaack is high for a read.
REQ-015 dmadone  output  1  one-cycle pulse per completed bus access.
REQ-016 busy  output  1  high from trig acceptance until the transfer ends.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states SHALL be IDLE, SETTLE, RD, RGAP, WR, WGAP.
REQ-019 IDLE: trig SHALL latch trigpage, clear idx[7:0], set halt=1 and busy=1, and enter SETTLE.
REQ-020 SETTLE: the engine SHALL wait SETTLE cycles with dmareq=0, then enter RD.
REQ-021 RD: the engine SHALL drive dmareq=1, dmawr=0, and dmaaddr={page,idx}.
REQ-022 RD: on dmaack the engine SHALL capture memrdata into dbuf, drop dmareq the next cycle, pulse dmadone, and enter RGAP.
REQ-023 RGAP: the engine SHALL spend exactly one cycle with dmareq=0, because the slave is rising-edge triggered, then enter WR.
REQ-024 WR: the engine SHALL drive dmareq=1, dmawr=1, dmaaddr=DESTADDR, and dmawdata=dbuf.
REQ-025 WR: on dmaack the engine SHALL drop dmareq, pulse dmadone, and enter WGAP.
REQ-026 WGAP: if idx==8'hFF, the engine SHALL enter IDLE with halt=0 and busy=0; otherwise it SHALL increment idx and enter RD.
REQ-027 idx SHALL be 8 bits, and the source address SHALL never carry into the page byte: 256 bytes, {page,00} to {page,FF}.
REQ-028 dmareq SHALL never be high in the cycle after a dmaack, and SHALL never deassert before dmaack.
REQ-029 dmaack in IDLE, SETTLE, RGAP or WGAP SHALL be ignored.
REQ-030 trig while busy SHALL be ignored; the page SHALL NOT change mid-transfer.
REQ-031 trig in the same cycle the transfer ends (WGAP with idx==FF) SHALL be ignored.
REQ-032 halt SHALL stay high continuously from acceptance to the end; no CPU access can interleave.
REQ-033 Transfer length SHALL be exactly 512 acknowledged accesses, alternating read then write, and 512 dmadone pulses.
REQ-034 No timeout SHALL exist; a missing ack stalls indefinitely with halt high.

Reset
REQ-035 rst SHALL force: state=IDLE, halt=0, busy=0, dmareq=0, dmawr=0, dmadone=0, dmaaddr=0, dmawdata=0, idx=0.
REQ-036 rst mid-transfer SHALL abort immediately, with no further request and halt low on the next cycle.
REQ-037 rst SHALL take priority over trig in the same cycle.

Verification
REQ-038 Basic copy: trig with trigpage=8'h02, source 0x0200..0x02FF = i^8'h5A, slave acks 1 cycle after the req edge -> 256 writes to 0x2004 with data i^8'h5A in order; halt high for the whole transfer; exactly 512 dmadone pulses; busy low after the last write.
REQ-039 Page wrap: trigpage=8'hFF -> last read address 0xFFFF; no access to 0x0000.
REQ-040 Handshake: slave ack delayed 0..5 random cycles -> dmareq held until ack; low for at least 1 cycle between accesses; never a duplicate access.
REQ-041 Retrigger: trig with page 8'h07 during the transfer of page 8'h03 -> ignored; all reads stay in 0x03xx; one transfer only.
REQ-042 Reset mid-op: rst asserted after the 100th write -> next cycle halt=0, dmareq=0, busy=0; a following trig with page 8'h04 restarts at 0x0400.
REQ-043 Stalled ack: ack withheld 1000 cycles in RD -> halt, dmareq and dmaaddr stable; transfer completes normally once ack resumes.
